// File: rtl/video_cap_pkg.sv
// Shared types and constants for the video frame capture block.
// Holds the capture FSM encoding, measurement counter width and a saturating increment.
package video_cap_pkg;

    localparam int CNT_W = 12;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        CAPTURE    = 2'd1,
        DONE       = 2'd2
    } cap_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/video_frame_meas.sv
// Per-frame geometry, pixel-sum and overflow accumulator; results latch on close (1 cycle).
// No backpressure: it observes the capture stream and never stalls it.
module video_frame_meas
    import video_cap_pkg::*;
#(
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic                  start,
    input  logic                  close,
    input  logic                  de,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [CNT_W-1:0]      meas_hdisp,
    output logic [CNT_W-1:0]      meas_vdisp,
    output logic [31:0]           frame_sum,
    output logic                  geom_err,
    output logic                  ovf_err
);

    logic             in_line;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] last_len;
    logic [CNT_W-1:0] line_cnt;
    logic             len_err;
    logic [31:0]      sum;
    logic             ovf;

    // A line still open at close counts as the last line of the frame.
    logic             open_bad;
    assign open_bad = in_line && (run_len != CNT_W'(IMG_HDISP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas_hdisp <= '0;
            meas_vdisp <= '0;
            frame_sum  <= '0;
            geom_err   <= 1'b0;
            ovf_err    <= 1'b0;
        end else if (close) begin
            meas_hdisp <= in_line ? run_len : last_len;
            meas_vdisp <= line_cnt;
            frame_sum  <= sum;
            geom_err   <= len_err | open_bad | (line_cnt != CNT_W'(IMG_VDISP));
            ovf_err    <= ovf;
        end
    end

    // The start cycle's own pixel seeds the accumulators of the new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_line  <= 1'b0;
            run_len  <= '0;
            last_len <= '0;
            line_cnt <= '0;
            len_err  <= 1'b0;
            sum      <= '0;
            ovf      <= 1'b0;
        end else if (start) begin
            in_line  <= de;
            run_len  <= de ? CNT_W'(1) : '0;
            line_cnt <= de ? CNT_W'(1) : '0;
            last_len <= '0;
            len_err  <= 1'b0;
            sum      <= wr ? 32'(data) : '0;
            ovf      <= de & ~wr;
        end else if (active) begin
            in_line <= de;
            if (de) begin
                run_len <= in_line ? sat_inc(run_len) : CNT_W'(1);
                if (!in_line) begin
                    line_cnt <= sat_inc(line_cnt);
                end
            end else if (in_line) begin
                last_len <= run_len;
                if (run_len != CNT_W'(IMG_HDISP)) begin
                    len_err <= 1'b1;
                end
            end
            if (wr) begin
                sum <= sum + 32'(data);
            end
            if (de && !wr) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_frame_capture.sv
// Captures video frames into NUM_BUFS memory slots; write port lags the pixel by 1 cycle.
// No backpressure: the memory must accept one write per cycle, excess pixels are dropped.
module video_frame_capture
    import video_cap_pkg::*;
#(
    parameter int IMG_HDISP   = 640,
    parameter int IMG_VDISP   = 480,
    parameter int DATA_WIDTH  = 24,
    parameter int START_FRAME = 1,
    parameter int NUM_BUFS    = 2,
    parameter int CONTINUOUS  = 0
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              video_vsync,
    input  logic                                              video_hsync,
    input  logic                                              video_de,
    input  logic [DATA_WIDTH-1:0]                             video_data,
    output logic                                              cap_wr_en,
    output logic [$clog2(NUM_BUFS*IMG_HDISP*IMG_VDISP)-1:0]   cap_wr_addr,
    output logic [DATA_WIDTH-1:0]                             cap_wr_data,
    output logic [CNT_W-1:0]                                  frame_cnt,
    output logic                                              cap_busy,
    output logic                                              cap_done,
    output logic [(NUM_BUFS > 1 ? $clog2(NUM_BUFS) : 1)-1:0]  cap_slot,
    output logic [CNT_W-1:0]                                  meas_hdisp,
    output logic [CNT_W-1:0]                                  meas_vdisp,
    output logic [31:0]                                       frame_sum,
    output logic                                              geom_err,
    output logic                                              ovf_err
);

    localparam int FRAME_PIX = IMG_HDISP * IMG_VDISP;
    localparam int AW        = $clog2(NUM_BUFS * FRAME_PIX);
    localparam int SW        = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
    localparam int IW        = $clog2(FRAME_PIX + 1);

    cap_state_e    state_q;
    cap_state_e    state_d;
    logic          vsync_d1;
    logic          fe;
    logic [SW-1:0] slot;
    logic [SW-1:0] slot_nxt;
    logic [SW-1:0] slot_eff;
    logic          last_slot;
    logic [IW-1:0] pix_idx;
    logic [IW-1:0] idx_eff;
    logic          start;
    logic          close;
    logic          active;
    logic          capture;
    logic          wr;

    // hsync is observed only; it never steers capture.
    logic          hsync_unused;
    assign hsync_unused = video_hsync;

    assign fe        = vsync_d1 & ~video_vsync;
    assign last_slot = (slot == SW'(NUM_BUFS - 1));
    assign slot_nxt  = last_slot ? '0 : slot + SW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        close   = 1'b0;
        unique case (state_q)
            WAIT_START: begin
                if (fe && (frame_cnt == CNT_W'(START_FRAME - 1))) begin
                    state_d = CAPTURE;
                    start   = 1'b1;
                end
            end
            CAPTURE: begin
                if (fe) begin
                    close = 1'b1;
                    if ((CONTINUOUS == 0) && last_slot) begin
                        state_d = DONE;
                    end else begin
                        start = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = WAIT_START;
            end
        endcase
    end

    // A pixel on the frame edge already belongs to the next frame and slot.
    assign active   = (state_d == CAPTURE);
    assign capture  = video_de & active;
    assign idx_eff  = start ? '0 : pix_idx;
    assign slot_eff = close ? slot_nxt : slot;
    assign wr       = capture && (idx_eff < IW'(FRAME_PIX));
    assign cap_busy = (state_q == CAPTURE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d1  <= 1'b0;
            frame_cnt <= '0;
            slot      <= '0;
            cap_slot  <= '0;
            cap_done  <= 1'b0;
            pix_idx   <= '0;
        end else begin
            vsync_d1 <= video_vsync;
            cap_done <= close;
            if (fe) begin
                frame_cnt <= sat_inc(frame_cnt);
            end
            if (close) begin
                slot     <= slot_nxt;
                cap_slot <= slot;
            end
            // Index parks at FRAME_PIX so an oversized frame cannot wrap into valid addresses.
            if (start) begin
                pix_idx <= capture ? IW'(1) : '0;
            end else if (capture && (pix_idx != IW'(FRAME_PIX))) begin
                pix_idx <= pix_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_wr_en   <= 1'b0;
            cap_wr_addr <= '0;
            cap_wr_data <= '0;
        end else begin
            cap_wr_en <= wr;
            if (wr) begin
                cap_wr_addr <= AW'(slot_eff) * AW'(FRAME_PIX) + AW'(idx_eff);
                cap_wr_data <= video_data;
            end
        end
    end

    video_frame_meas #(
        .IMG_HDISP  (IMG_HDISP),
        .IMG_VDISP  (IMG_VDISP),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_meas (
        .clk        (clk),
        .rst        (rst),
        .active     (active),
        .start      (start),
        .close      (close),
        .de         (video_de),
        .wr         (wr),
        .data       (video_data),
        .meas_hdisp (meas_hdisp),
        .meas_vdisp (meas_vdisp),
        .frame_sum  (frame_sum),
        .geom_err   (geom_err),
        .ovf_err    (ovf_err)
    );

endmodule

// File: tb/tb_video_frame_capture.sv
// Bench for video_frame_capture: three instances (stop-after-2, continuous, start-at-3) share one stimulus stream.
module tb_video_frame_capture;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int NB = 2;
    localparam int AW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vsync, hsync, de;
    logic [23:0] data;

    logic [2:0]    wr_en, busy, done, geom, ovf;
    logic [AW-1:0] wr_addr [3];
    logic [23:0]   wr_data [3];
    logic [11:0]   fcnt [3];
    logic [0:0]    slot_o [3];
    logic [11:0]   hd [3];
    logic [11:0]   vd [3];
    logic [31:0]   fsum [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        video_frame_capture #(
            .IMG_HDISP   (H),
            .IMG_VDISP   (V),
            .DATA_WIDTH  (24),
            .START_FRAME (g == 2 ? 3 : 1),
            .NUM_BUFS    (NB),
            .CONTINUOUS  (g == 1 ? 1 : 0)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .video_vsync (vsync),
            .video_hsync (hsync),
            .video_de    (de),
            .video_data  (data),
            .cap_wr_en   (wr_en[g]),
            .cap_wr_addr (wr_addr[g]),
            .cap_wr_data (wr_data[g]),
            .frame_cnt   (fcnt[g]),
            .cap_busy    (busy[g]),
            .cap_done    (done[g]),
            .cap_slot    (slot_o[g]),
            .meas_hdisp  (hd[g]),
            .meas_vdisp  (vd[g]),
            .frame_sum   (fsum[g]),
            .geom_err    (geom[g]),
            .ovf_err     (ovf[g])
        );
    end

    typedef struct {
        int          nlines;
        int          first_len;
        int          rest_len;
        bit          de_at_fe;
        logic [23:0] base;
        logic [11:0] exp_h;
        logic [11:0] exp_v;
        logic [31:0] exp_sum;
        bit          exp_geom;
        bit          exp_ovf;
    } fvec_t;

    typedef struct {
        int          dut;
        logic [AW-1:0] addr;
        logic [23:0] data;
    } wexp_t;

    typedef struct {
        int          dut;
        logic [0:0]  slot;
        logic [11:0] h;
        logic [11:0] v;
        logic [31:0] sum;
        bit          geom;
        bit          ovf;
    } dexp_t;

    fvec_t tab [4];
    wexp_t wq [$];
    dexp_t dq [$];
    int    checks = 0;
    int    errors = 0;
    bit    c_first = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int first_of(input int g);
        return (g == 2) ? 3 : 1;
    endfunction

    function automatic bit captured(input int g, input int k);
        return (k >= first_of(g)) && ((g == 1) || (k < first_of(g) + NB));
    endfunction

    function automatic int slot_of(input int g, input int k);
        return (k - first_of(g)) % NB;
    endfunction

    task automatic push_wr(input int k, input int idx, input logic [23:0] px);
        wexp_t e;
        for (int g = 0; g < 3; g++) begin
            if (captured(g, k) && idx < H * V) begin
                e.dut  = g;
                e.addr = AW'(slot_of(g, k) * H * V + idx);
                e.data = px;
                wq.push_back(e);
            end
        end
    endtask

    task automatic push_done(input int k, input int r);
        dexp_t e;
        for (int g = 0; g < 3; g++) begin
            if (captured(g, k)) begin
                e.dut  = g;
                e.slot = 1'(slot_of(g, k));
                e.h    = tab[r].exp_h;
                e.v    = tab[r].exp_v;
                e.sum  = tab[r].exp_sum;
                e.geom = tab[r].exp_geom;
                e.ovf  = tab[r].exp_ovf;
                dq.push_back(e);
            end
        end
    endtask

    task automatic monitor();
        int j;
        for (int g = 0; g < 3; g++) begin
            if (wr_en[g]) begin
                j = -1;
                for (int i = 0; i < wq.size(); i++) begin
                    if (wq[i].dut == g) begin
                        j = i;
                        break;
                    end
                end
                if (j < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr d%0d: got write addr %0d data 0x%0h, expected no write",
                             g, wr_addr[g], wr_data[g]);
                end else begin
                    chk($sformatf("wr_addr d%0d", g), 64'(wr_addr[g]), 64'(wq[j].addr));
                    chk($sformatf("wr_data d%0d", g), 64'(wr_data[g]), 64'(wq[j].data));
                    wq.delete(j);
                end
                if (g == 2 && !c_first) begin
                    c_first = 1'b1;
                    chk("first_wr_frame_cnt d2", 64'(fcnt[2]), 64'd3);
                end
            end
            if (done[g]) begin
                j = -1;
                for (int i = 0; i < dq.size(); i++) begin
                    if (dq[i].dut == g) begin
                        j = i;
                        break;
                    end
                end
                if (j < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done d%0d: got cap_done slot %0d, expected no done", g, slot_o[g]);
                end else begin
                    chk($sformatf("cap_slot d%0d", g),   64'(slot_o[g]), 64'(dq[j].slot));
                    chk($sformatf("meas_hdisp d%0d", g), 64'(hd[g]),     64'(dq[j].h));
                    chk($sformatf("meas_vdisp d%0d", g), 64'(vd[g]),     64'(dq[j].v));
                    chk($sformatf("frame_sum d%0d", g),  64'(fsum[g]),   64'(dq[j].sum));
                    chk($sformatf("geom_err d%0d", g),   64'(geom[g]),   64'(dq[j].geom));
                    chk($sformatf("ovf_err d%0d", g),    64'(ovf[g]),    64'(dq[j].ovf));
                    dq.delete(j);
                end
            end
        end
    endtask

    task automatic step(input logic vs, input logic hs, input logic d, input logic [23:0] px);
        vsync = vs;
        hsync = hs;
        de    = d;
        data  = px;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_wr d%0d", tag, g), 64'({wr_en[g], wr_addr[g], wr_data[g]}), 64'd0);
            chk($sformatf("%s_status d%0d", tag, g), 64'({fcnt[g], busy[g], done[g], slot_o[g]}), 64'd0);
            chk($sformatf("%s_meas d%0d", tag, g), 64'({hd[g], vd[g], geom[g], ovf[g]}), 64'd0);
            chk($sformatf("%s_sum d%0d", tag, g), 64'(fsum[g]), 64'd0);
        end
    endtask

    // One frame starting with its frame edge; r < 0 drives an empty trailing frame.
    task automatic frame(input int k, input int r, input int pr);
        int          idx;
        int          len;
        logic [23:0] px;
        if (pr >= 0) push_done(k - 1, pr);
        if (r < 0 || !tab[r].de_at_fe) repeat (3) step(1'b0, 1'b0, 1'b0, 24'd0);
        if (r >= 0) begin
            idx = 0;
            for (int l = 0; l < tab[r].nlines; l++) begin
                len = (l == 0) ? tab[r].first_len : tab[r].rest_len;
                for (int p = 0; p < len; p++) begin
                    px = tab[r].base + 24'(idx);
                    push_wr(k, idx, px);
                    step(1'b0, 1'b0, 1'b1, px);
                    idx++;
                end
                step(1'b0, 1'b1, 1'b0, 24'd0);
                step(1'b0, 1'b1, 1'b0, 24'd0);
                step(1'b0, 1'b0, 1'b0, 24'd0);
            end
            step(1'b1, 1'b0, 1'b0, 24'd0);
            step(1'b1, 1'b0, 1'b0, 24'd0);
        end
    endtask

    task automatic run_stream(input int first_row, input int nrows);
        step(1'b1, 1'b0, 1'b0, 24'd0);
        step(1'b1, 1'b0, 1'b0, 24'd0);
        for (int f = 0; f < nrows; f++) begin
            frame(f + 1, first_row + f, (f == 0) ? -1 : first_row + f - 1);
        end
        frame(nrows + 1, -1, first_row + nrows - 1);
        repeat (4) step(1'b0, 1'b0, 1'b0, 24'd0);
    endtask

    task automatic end_checks(input string tag, input int exp_fcnt, input logic [2:0] exp_busy);
        int nw;
        int nd;
        for (int g = 0; g < 3; g++) begin
            nw = 0;
            nd = 0;
            foreach (wq[i]) if (wq[i].dut == g) nw++;
            foreach (dq[i]) if (dq[i].dut == g) nd++;
            chk($sformatf("%s_frame_cnt d%0d", tag, g), 64'(fcnt[g]), 64'(exp_fcnt));
            chk($sformatf("%s_busy d%0d", tag, g), 64'(busy[g]), 64'(exp_busy[g]));
            chk($sformatf("%s_missing_wr d%0d", tag, g), 64'(nw), 64'd0);
            chk($sformatf("%s_missing_done d%0d", tag, g), 64'(nd), 64'd0);
        end
    endtask

    initial begin
        // nlines, first_len, rest_len, de_at_fe, base, exp_h, exp_v, exp_sum, exp_geom, exp_ovf
        tab[0] = '{4, 8, 8, 1'b0, 24'h0,      12'd8, 12'd4, 32'd496,       1'b0, 1'b0};
        tab[1] = '{4, 8, 8, 1'b1, 24'h0,      12'd8, 12'd4, 32'd496,       1'b0, 1'b0};
        tab[2] = '{5, 9, 8, 1'b0, 24'h0,      12'd8, 12'd5, 32'd496,       1'b1, 1'b1};
        tab[3] = '{3, 8, 8, 1'b0, 24'hABC000, 12'd8, 12'd3, 32'd270139668, 1'b1, 1'b0};

        rst   = 1'b1;
        vsync = 1'b0;
        hsync = 1'b0;
        de    = 1'b0;
        data  = '0;
        @(posedge clk);
        #1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 24'd0);
        reset_checks("reset");
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 24'd0);

        // Four frames: clean, clean with pixel on the edge, oversized, short with offset data.
        run_stream(0, 4);
        end_checks("stream", 5, 3'b010);

        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 24'd0);
        rst = 1'b0;
        wq.delete();
        dq.delete();
        step(1'b1, 1'b0, 1'b0, 24'd0);
        step(1'b1, 1'b0, 1'b0, 24'd0);
        step(1'b0, 1'b0, 1'b0, 24'd0);
        for (int i = 0; i < 12; i++) begin
            push_wr(1, i, 24'(i));
            step(1'b0, 1'b0, 1'b1, 24'(i));
        end
        rst = 1'b1;
        #1;
        reset_checks("midreset");
        wq.delete();
        dq.delete();
        step(1'b0, 1'b0, 1'b0, 24'd0);
        step(1'b0, 1'b0, 1'b0, 24'd0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 24'd0);
        step(1'b0, 1'b0, 1'b0, 24'd0);

        run_stream(0, 1);
        end_checks("restart", 2, 3'b011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_frame_capture.md
VIDEO_FRAME_CAPTURE -- requirements
Module: video_frame_capture

Interface
REQ-001 SHALL have parameter IMG_HDISP, default 640, expected active pixels per line.
REQ-002 SHALL have parameter IMG_VDISP, default 480, expected active lines per frame.
REQ-003 SHALL have parameter DATA_WIDTH, default 24, pixel word width.
REQ-004 SHALL have parameter START_FRAME, default 1, number of vsync trailing edges before the first captured frame (legal range >=1).
REQ-005 SHALL have parameter NUM_BUFS, default 2, number of frame slots in the capture memory.
REQ-006 SHALL have parameter CONTINUOUS, default 0; 0 = stop after NUM_BUFS frames, 1 = ring-overwrite forever.
REQ-007 SHALL have ports: clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-008 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have ports: video_vsync/video_hsync/video_de  in  1 each  active-high video timing; video_data  in  DATA_WIDTH  pixel.
REQ-010 SHALL have ports: cap_wr_en  out  1; cap_wr_addr  out  clog2(NUM_BUFS*IMG_HDISP*IMG_VDISP); cap_wr_data  out  DATA_WIDTH  memory write port.
REQ-011 SHALL have ports: frame_cnt  out  12  trailing-edge count; cap_busy  out  1  state==CAPTURE; cap_done  out  1  one-cycle frame-complete pulse; cap_slot  out  clog2(NUM_BUFS)  slot of the completed frame.
REQ-012 SHALL have ports: meas_hdisp  out  12, meas_vdisp  out  12, frame_sum  out  32, geom_err  out  1, ovf_err  out  1  results latched for the completed frame.

Function
REQ-013 SHALL detect frame edge fe = vsync_d1 & ~video_vsync, where vsync_d1 is video_vsync registered one cycle.
REQ-014 SHALL increment frame_cnt on each fe, saturating at 4095.
REQ-015 SHALL implement states WAIT_START, CAPTURE, DONE; reset state WAIT_START.
REQ-016 SHALL move WAIT_START->CAPTURE on the fe that brings frame_cnt to START_FRAME; slot 0 is used first.
REQ-017 In CAPTURE, SHALL on each fe close the current frame: pulse cap_done, latch results, and advance the slot modulo NUM_BUFS.
REQ-018 SHALL move CAPTURE->DONE on the fe that closes slot NUM_BUFS-1 when CONTINUOUS=0; DONE is left only by reset.
REQ-019 SHALL count a pixel sampled with video_de=1 in the fe cycle as pixel 0 of the new frame.
REQ-020 For each captured pixel (video_de=1 in CAPTURE, or in the entering fe cycle), SHALL assert cap_wr_en one cycle later with cap_wr_addr = slot*IMG_HDISP*IMG_VDISP + pixel index, cap_wr_data = pixel (latency 1).
REQ-021 SHALL suppress writes once pixel index reaches IMG_HDISP*IMG_VDISP and flag overflow for that frame.
REQ-022 SHALL measure line length as de run length, line count as de rising edges; geom_err = any line length != IMG_HDISP or line count != IMG_VDISP.
REQ-023 SHALL accumulate frame_sum as the modulo-2^32 sum of zero-extended written pixels (suppressed pixels excluded).
REQ-024 SHALL hold meas_hdisp (last line length), meas_vdisp, frame_sum, geom_err, ovf_err, cap_slot stable from the cap_done cycle until the next cap_done.
REQ-025 SHALL ignore video_hsync functionally (monitored only; no effect on outputs).
REQ-026 SHALL saturate meas counters at 4095.

Reset
REQ-027 SHALL on rst clear all outputs to 0, frame_cnt to 0, slot to 0, vsync_d1 to 0, state to WAIT_START, asynchronously.
REQ-028 SHALL discard a partially captured frame on reset mid-capture; no cap_done for it.

Structure
REQ-029 SHALL place the state enum (WAIT_START, CAPTURE, DONE) and the 12-bit counter width constant in shared package video_cap_pkg.
REQ-030 SHALL implement the per-frame geometry/sum accumulator as sub-module video_frame_meas; the FSM and address generation stay in the top.

Verification (IMG_HDISP=8, IMG_VDISP=4, NUM_BUFS=2, START_FRAME=1 unless stated)
REQ-031 Clean 8x4 frames, data=index -> writes addr 0..31 in frame 1, 32..63 in frame 2; cap_done with meas 8/4, frame_sum=496, errors 0; then DONE, no further writes.
REQ-032 CONTINUOUS=1, 3 frames -> third frame writes addr 0..31, cap_slot sequence 0,1,0.
REQ-033 Line of 9 pixels in a 5-line frame -> geom_err=1, ovf_err=1, exactly 32 writes.
REQ-034 de=1 coincident with fe -> that pixel written at addr 0 of the new slot.
REQ-035 rst asserted mid-frame 1 -> outputs 0 immediately; capture restarts at the next START_FRAME edge.
REQ-036 START_FRAME=3 -> no writes until third fe; frame_cnt=3 at first write.
